// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the requester-side and controller-side signals around the
// SDRAM port arbiter. The slave modport is the arbiter. The master modport
// is its environment: the display read path, the write FIFO drain and the
// sdram_controller command port.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 16
);
   // display read requester
   logic              rd_req;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_dout;
   logic              rd_err;
   // write requester
   logic              wr_req;
   logic [ADDR_W-1:0] wr_req_addr;
   logic [DATA_W-1:0] wr_req_data;
   logic              wr_ack;
   logic              wr_starved;
   // controller command port
   logic              ctl_rd_enable;
   logic [ADDR_W-1:0] ctl_rd_addr;
   logic              ctl_rd_ready;
   logic [DATA_W-1:0] ctl_rd_data;
   logic              ctl_wr_enable;
   logic [ADDR_W-1:0] ctl_wr_addr;
   logic [DATA_W-1:0] ctl_wr_data;
   logic              ctl_wr_addr_inc;
   logic              ctl_busy;
   // status
   logic [1:0]        owner;

   modport slave (
      input  rd_req, rd_req_addr, wr_req, wr_req_addr, wr_req_data,
             ctl_rd_ready, ctl_rd_data, ctl_wr_addr_inc, ctl_busy,
      output rd_ack, rd_valid, rd_dout, rd_err, wr_ack, wr_starved,
             ctl_rd_enable, ctl_rd_addr, ctl_wr_enable, ctl_wr_addr,
             ctl_wr_data, owner
   );

   modport master (
      output rd_req, rd_req_addr, wr_req, wr_req_addr, wr_req_data,
             ctl_rd_ready, ctl_rd_data, ctl_wr_addr_inc, ctl_busy,
      input  rd_ack, rd_valid, rd_dout, rd_err, wr_ack, wr_starved,
             ctl_rd_enable, ctl_rd_addr, ctl_wr_enable, ctl_wr_addr,
             ctl_wr_data, owner
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of the single sdram_controller command port.
// Display reads have absolute priority over writes. A write is never
// preempted once issued. Reads that the controller never answers are
// abandoned after RD_TIMEOUT cycles. A saturating age counter flags writes
// that have waited WR_AGE_MAX cycles or more; it is status only.
// All outputs are registered except wr_ack, which is the controller's
// accept pulse qualified by the write-issue state.
module sdram_port_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 16,
   parameter int RD_TIMEOUT = 64,   // keep >= 2
   parameter int WR_AGE_MAX = 1023
) (
   input logic                  clk,
   input logic                  rst,
   sdram_port_arbiter_if.slave  bus
);

   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
   localparam int AGE_W = $clog2(WR_AGE_MAX + 1);

   localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(RD_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(WR_AGE_MAX);
   localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RD_ISSUE = 2'd1;
   localparam logic [1:0] S_RD_WAIT  = 2'd2;
   localparam logic [1:0] S_WR_ISSUE = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,  wr_data_d;
   logic [DATA_W-1:0] rd_dout_q,  rd_dout_d;
   logic              rd_ack_q,   rd_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_err_q,   rd_err_d;
   logic              rd_en_q,    rd_en_d;
   logic              wr_en_q,    wr_en_d;
   logic [TMO_W-1:0]  tmo_q,      tmo_d;
   logic [AGE_W-1:0]  age_q,      age_d;
   logic              starved_q,  starved_d;
   logic [1:0]        owner_q,    owner_d;
   logic              wr_ack_s;

   // Controller accept counts as an ack only while our write is on the bus.
   assign wr_ack_s = bus.ctl_wr_addr_inc && (state_q == S_WR_ISSUE);

   // Arbitration FSM: next state, address/data latching and output pulses.
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_dout_d  = rd_dout_q;
      rd_ack_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_err_d   = 1'b0;
      rd_en_d    = 1'b0;
      wr_en_d    = wr_en_q;
      tmo_d      = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ctl_busy) begin
               state_d = S_IDLE;
            end else if (bus.rd_req) begin
               // read wins a tie; a pending write simply waits for IDLE again
               rd_addr_d = bus.rd_req_addr;
               rd_ack_d  = 1'b1;
               rd_en_d   = 1'b1;
               state_d   = S_RD_ISSUE;
            end else if (bus.wr_req) begin
               wr_addr_d = bus.wr_req_addr;
               wr_data_d = bus.wr_req_data;
               wr_en_d   = 1'b1;
               state_d   = S_WR_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_ISSUE: begin
            tmo_d   = TMO_LOAD;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.ctl_rd_ready) begin
               rd_dout_d  = bus.ctl_rd_data;
               rd_valid_d = 1'b1;
               state_d    = S_IDLE;
            end else if (tmo_q <= TMO_ONE) begin
               // counter reaches zero this cycle: give up, keep old rd_dout
               rd_err_d = 1'b1;
               tmo_d    = '0;
               state_d  = S_IDLE;
            end else begin
               tmo_d = tmo_q - TMO_ONE;
            end
         end
         S_WR_ISSUE: begin
            if (bus.ctl_wr_addr_inc) begin
               wr_en_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               wr_en_d = 1'b1;
            end
         end
         default: begin
            wr_en_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Owner code follows the state being entered so it lines up with the state.
   always_comb begin
      case (state_d)
         S_RD_ISSUE: owner_d = 2'd1;
         S_RD_WAIT:  owner_d = 2'd1;
         S_WR_ISSUE: owner_d = 2'd2;
         default:    owner_d = 2'd0;
      endcase
   end

   // Write age: counts pending cycles outside write issue, saturates at the limit.
   always_comb begin
      if (!bus.wr_req || wr_ack_s) begin
         age_d = '0;
      end else if ((state_q != S_WR_ISSUE) && (age_q < AGE_LIMIT)) begin
         age_d = age_q + AGE_ONE;
      end else begin
         age_d = age_q;
      end
      starved_d = (age_q >= AGE_LIMIT);
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_dout_q  <= '0;
         rd_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         tmo_q      <= '0;
         age_q      <= '0;
         starved_q  <= 1'b0;
         owner_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_dout_q  <= rd_dout_d;
         rd_ack_q   <= rd_ack_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         tmo_q      <= tmo_d;
         age_q      <= age_d;
         starved_q  <= starved_d;
         owner_q    <= owner_d;
      end
   end

   assign bus.rd_ack        = rd_ack_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_dout       = rd_dout_q;
   assign bus.rd_err        = rd_err_q;
   assign bus.wr_ack        = wr_ack_s;
   assign bus.wr_starved    = starved_q;
   assign bus.ctl_rd_enable = rd_en_q;
   assign bus.ctl_rd_addr   = rd_addr_q;
   assign bus.ctl_wr_enable = wr_en_q;
   assign bus.ctl_wr_addr   = wr_addr_q;
   assign bus.ctl_wr_data   = wr_data_q;
   assign bus.owner         = owner_q;

endmodule
